apb_cmd_master: RTL
===================

Name: apb_cmd_master

Overview:
- APB3 requester: converts a simple valid/ready command stream from the system side into single APB transfers toward the memory-mapped APB slave.
- Sequences each command through SETUP and ACCESS, honours PREADY wait states and aborts hung transfers with a timeout.
- Returns read data and error status on a held response channel; one transfer in flight.

Parameters:
- ADDR_W, 32, PADDR / cmd_addr width
- DATA_W, 32, PWDATA / PRDATA / cmd_wdata / rsp_rdata width
- TIMEOUT, 16, max ACCESS cycles without PREADY before abort; 0 = timeout disabled
- CNT_W, 8, width of the ACCESS-cycle counter; must hold TIMEOUT

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  reset; asynchronous, active-low; clock is PCLK
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at PCLK rise
- cmd_addr  in  ADDR_W  target address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset (async assert, sync release on PCLK): state IDLE.
  - All outputs 0, except cmd_ready = 1 in IDLE.
  - ACCESS counter = 0.
  - A command or response in progress is discarded; no response is issued for it.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB and rsp outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA; next state SETUP.
- SETUP: PSELx = 1, PENABLE = 0, cmd_ready = 0; always lasts exactly 1 cycle; next state ACCESS.
- ACCESS:
  - PSELx = 1, PENABLE = 1. PADDR/PWRITE/PWDATA stay stable from SETUP until the transfer ends.
  - Counter increments each ACCESS cycle in which PREADY = 0.
  - PREADY = 1 at a rising edge ends the transfer. At that edge:
    - Capture PSLVERR into rsp_err.
    - Capture PRDATA into rsp_rdata if read; rsp_rdata = 0 if write.
    - rsp_timeout = 0. Next state RESP.
  - Timeout: TIMEOUT != 0, PREADY = 0 and counter == TIMEOUT-1 at an edge. Next state RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - PREADY = 1 on the timeout edge: the ready completion wins.
- RESP:
  - PSELx = 0, PENABLE = 0, rsp_valid = 1, cmd_ready = 0; rsp_* fields held stable.
  - rsp_ready = 1: next state IDLE, rsp_valid drops next cycle, counter cleared.
- No back-to-back overlap.
  - Minimum command-to-command spacing is 4 cycles: IDLE, SETUP, ACCESS, RESP with rsp_ready already high.
  - cmd_valid is ignored outside IDLE.
- PADDR/PWRITE/PWDATA retain their last values while idle; they change only on command accept.
- Inputs PRDATA/PSLVERR are sampled only on the completing edge. PREADY in SETUP, RESP or IDLE is ignored.

Test Plan:
- Zero-wait read:
  - Stimulus: responder asserts PREADY on the first ACCESS cycle with PRDATA = 0xDEADBEEF; cmd read addr 0x0000_0010; rsp_ready = 1.
  - Response: SETUP 1 cycle, ACCESS 1 cycle, rsp_valid with rdata 0xDEADBEEF and err 0, exactly 3 cycles after accept.
- Wait-state write:
  - Stimulus: write addr 0x0000_0103, wdata 0x12345678; responder holds PREADY low for 3 ACCESS cycles.
  - Response: PENABLE high 4 cycles; PADDR/PWDATA constant throughout; rsp_rdata 0, rsp_err 0.
- Slave error:
  - Stimulus: PSLVERR = 1 with PREADY on a read of addr 0x0000_1000.
  - Response: rsp_err 1, rsp_timeout 0, rsp_rdata = PRDATA.
- Timeout:
  - Stimulus: TIMEOUT = 16, PREADY stuck 0.
  - Response: exactly 16 ACCESS cycles, then rsp_err 1, rsp_timeout 1, rdata 0; PSELx low in RESP.
  - Re-run with TIMEOUT = 0 and PREADY released after 40 cycles: normal completion, no timeout.
- Backpressure:
  - Stimulus: rsp_ready = 0 for 5 cycles; cmd_valid held high with a second command.
  - Response: rsp held stable, cmd_ready 0, no new SETUP; second command accepted only in the cycle after rsp_ready = 1.
- Reset mid-transfer:
  - Stimulus: assert PRESETn low during ACCESS.
  - Response: PSELx/PENABLE/rsp_valid = 0 immediately (asynchronous); after release, IDLE with cmd_ready 1 and no stale response.

Source files
------------

// File: rtl/apb_cmd_master.sv
`default_nettype none
// =============================================================================
// apb_cmd_master : valid/ready command stream to single APB3 transfers
// Revision 1.0
// =============================================================================
module apb_cmd_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_write,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               pwdata_d = cmd_wdata;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!PREADY) begin
               cnt_d = cnt_q + 1'b1;
            end
            // A ready completion on the timeout edge takes priority over the abort
            if (PREADY) begin
               rsp_err_d     = PSLVERR;
               rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
               rsp_timeout_d = 1'b0;
               state_d       = ST_RESP;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               rsp_err_d     = 1'b1;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b1;
               state_d       = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_d   = (state_d == ST_ACCESS);
      rsp_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         cmd_ready_q   <= 1'b1;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cmd_ready_q   <= cmd_ready_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign PSELx       = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire
